// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Program-counter and fetch-redirect stage. Takes the EX-stage branch
//   result and jump decode, computes the redirect target, steers fetch,
//   flushes the younger IF/ID instructions and counts taken redirects.
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   stall               hold PC, no advance
//   imem_ready          instruction memory accepts the current fetch
//   resolve_valid       branch/jump present in EX this cycle
//   branch_taken        conditional branch comparator result
//   is_jal, is_jalr     EX jump decode
//   ex_pc, ex_imm       EX instruction PC and sign-extended immediate
//   rs1_data            forwarded JALR base
//   pc, fetch_valid     fetch request
//   flush               kill IF/ID instructions
//   taken_cnt           saturating count of redirects taken
//   misalign_err        sticky: redirect target not 4-byte aligned
module pc_redirect_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            resolve_valid,
  input  logic            branch_taken,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic [31:0]     taken_cnt,
  output logic            misalign_err
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      fcnt, fcnt_nxt;
  logic [XLEN-1:0] pc_nxt, target, jalr_sum;
  logic            redirect, cnt_inc, set_mis, advance;

  // JALR clears bit 0 of the sum; only bit 1 decides misalignment.
  assign jalr_sum = rs1_data + ex_imm;
  assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
  assign redirect = resolve_valid & (is_jal | is_jalr | branch_taken);
  assign advance  = imem_ready & ~stall;

  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    pc_nxt      = pc;
    cnt_inc     = 1'b0;
    set_mis     = 1'b0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        fetch_valid = 1'b1;
        // Redirect wins over stall and drops any unaccepted request.
        if (redirect) begin
          if (target[1]) begin
            state_nxt = HALT;
            set_mis   = 1'b1;
          end else begin
            pc_nxt    = target;
            state_nxt = FLUSH;
            fcnt_nxt  = 3'(FLUSH_CYCLES - 1);
            cnt_inc   = 1'b1;
          end
        end else if (advance) begin
          pc_nxt = pc + XLEN'(4);
        end
      end
      FLUSH: begin
        // EX holds a bubble here, so resolve inputs are ignored.
        fetch_valid = 1'b1;
        flush       = 1'b1;
        if (advance) pc_nxt = pc + XLEN'(4);
        if (fcnt == 3'd0) state_nxt = FETCH;
        else              fcnt_nxt  = fcnt - 3'd1;
      end
      default: ; // HALT: only reset leaves
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fcnt         <= '0;
      pc           <= RESET_PC;
      taken_cnt    <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      pc    <= pc_nxt;
      if (cnt_inc && taken_cnt != 32'hFFFF_FFFF) taken_cnt <= taken_cnt + 32'd1;
      if (set_mis) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;
  logic        clk = 1'b0;
  logic        rst_n, stall, imem_ready, resolve_valid, branch_taken, is_jal, is_jalr;
  logic [31:0] ex_pc, ex_imm, rs1_data, pc, taken_cnt;
  logic        fetch_valid, flush, misalign_err;
  int          pass_cnt = 0, total = 0;

  pc_redirect_unit #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready),
    .resolve_valid(resolve_valid), .branch_taken(branch_taken),
    .is_jal(is_jal), .is_jalr(is_jalr), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .rs1_data(rs1_data), .pc(pc), .fetch_valid(fetch_valid), .flush(flush),
    .taken_cnt(taken_cnt), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    stall = 0; imem_ready = 1; resolve_valid = 0; branch_taken = 0;
    is_jal = 0; is_jalr = 0; ex_pc = 0; ex_imm = 0; rs1_data = 0;
  endtask

  // Reset, release, and take the IDLE->FETCH edge: leaves pc=0 in FETCH.
  task automatic reset_to_fetch();
    idle_in(); rst_n = 0; step(); step(); rst_n = 1; step();
  endtask

  task automatic test_reset();
    idle_in(); rst_n = 0; step(); step();
    total++; if (pc !== 32'h0 || fetch_valid !== 0 || flush !== 0 || taken_cnt !== 0 || misalign_err !== 0)
      $display("FAIL reset_vals pc=%h fv=%b fl=%b cnt=%0d mis=%b", pc, fetch_valid, flush, taken_cnt, misalign_err); else pass_cnt++;
    rst_n = 1; #1;
    total++; if (fetch_valid !== 0) $display("FAIL idle_fv got %b exp 0", fetch_valid); else pass_cnt++;
    step();
    total++; if (fetch_valid !== 1 || pc !== 32'h0) $display("FAIL fetch_start fv=%b pc=%h exp 1/0", fetch_valid, pc); else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (pc !== 32'(4*i)) $display("FAIL pc_step%0d got %h exp %h", i, pc, 32'(4*i)); else pass_cnt++;
    end
  endtask

  task automatic test_taken_branch();
    reset_to_fetch();
    resolve_valid = 1; branch_taken = 1; ex_pc = 32'h40; ex_imm = 32'h20;
    step(); idle_in();
    total++; if (pc !== 32'h60 || flush !== 1 || taken_cnt !== 1)
      $display("FAIL br_redirect pc=%h fl=%b cnt=%0d exp 60/1/1", pc, flush, taken_cnt); else pass_cnt++;
    step();
    total++; if (pc !== 32'h64 || flush !== 1) $display("FAIL br_flush2 pc=%h fl=%b exp 64/1", pc, flush); else pass_cnt++;
    step();
    total++; if (pc !== 32'h68 || flush !== 0 || fetch_valid !== 1)
      $display("FAIL br_flush_end pc=%h fl=%b fv=%b exp 68/0/1", pc, flush, fetch_valid); else pass_cnt++;
  endtask

  task automatic test_jalr();
    reset_to_fetch();
    resolve_valid = 1; is_jalr = 1; rs1_data = 32'h1003; ex_imm = 32'h1;
    step(); idle_in();
    total++; if (pc !== 32'h1004 || flush !== 1 || taken_cnt !== 1)
      $display("FAIL jalr_target pc=%h fl=%b cnt=%0d exp 1004/1/1", pc, flush, taken_cnt); else pass_cnt++;
    step(); step();
    total++; if (pc !== 32'h100C || flush !== 0) $display("FAIL jalr_after pc=%h fl=%b exp 100c/0", pc, flush); else pass_cnt++;
    resolve_valid = 1; is_jalr = 1; rs1_data = 32'h1001; ex_imm = 32'h1;
    step(); idle_in();
    total++; if (misalign_err !== 1 || fetch_valid !== 0 || flush !== 0 || pc !== 32'h100C || taken_cnt !== 1)
      $display("FAIL jalr_halt mis=%b fv=%b fl=%b pc=%h cnt=%0d exp 1/0/0/100c/1", misalign_err, fetch_valid, flush, pc, taken_cnt); else pass_cnt++;
    resolve_valid = 1; is_jal = 1; ex_pc = 32'h0; ex_imm = 32'h80;
    step(); step(); idle_in();
    total++; if (misalign_err !== 1 || fetch_valid !== 0 || pc !== 32'h100C)
      $display("FAIL halt_sticky mis=%b fv=%b pc=%h exp 1/0/100c", misalign_err, fetch_valid, pc); else pass_cnt++;
  endtask

  task automatic test_stall_vs_redirect();
    reset_to_fetch();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 32'h0) $display("FAIL stall_hold%0d got %h exp 0", i, pc); else pass_cnt++;
    end
    resolve_valid = 1; is_jal = 1; ex_pc = 32'h100; ex_imm = 32'h10;
    step(); idle_in();
    total++; if (pc !== 32'h110 || flush !== 1 || taken_cnt !== 1)
      $display("FAIL stall_redirect pc=%h fl=%b cnt=%0d exp 110/1/1", pc, flush, taken_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    reset_to_fetch();
    repeat (4) step();
    total++; if (pc !== 32'h10) $display("FAIL bp_start got %h exp 10", pc); else pass_cnt++;
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 32'h10 || fetch_valid !== 1) $display("FAIL bp_hold%0d pc=%h fv=%b exp 10/1", i, pc, fetch_valid); else pass_cnt++;
    end
    imem_ready = 1; step();
    total++; if (pc !== 32'h14) $display("FAIL bp_release got %h exp 14", pc); else pass_cnt++;
    resolve_valid = 1; branch_taken = 0; ex_pc = 32'h40; ex_imm = 32'h20;
    step(); idle_in();
    total++; if (pc !== 32'h18 || flush !== 0 || taken_cnt !== 0)
      $display("FAIL not_taken pc=%h fl=%b cnt=%0d exp 18/0/0", pc, flush, taken_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap_flush_reset();
    reset_to_fetch();
    resolve_valid = 1; is_jal = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC;
    step();
    total++; if (pc !== 32'hFFFF_FFFC || flush !== 1) $display("FAIL wrap_target pc=%h fl=%b exp fffffffc/1", pc, flush); else pass_cnt++;
    ex_pc = 32'h200; ex_imm = 32'h0;   // resolve during FLUSH must be ignored
    step(); idle_in();
    total++; if (pc !== 32'h0 || flush !== 1 || taken_cnt !== 1)
      $display("FAIL wrap_ignore pc=%h fl=%b cnt=%0d exp 0/1/1", pc, flush, taken_cnt); else pass_cnt++;
    rst_n = 0; #1;
    total++; if (flush !== 0 || fetch_valid !== 0 || taken_cnt !== 0 || pc !== 32'h0)
      $display("FAIL midflush_reset fl=%b fv=%b cnt=%0d pc=%h exp 0/0/0/0", flush, fetch_valid, taken_cnt, pc); else pass_cnt++;
    step(); rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_taken_branch();
    test_jalr();
    test_stall_vs_redirect();
    test_backpressure();
    test_wrap_flush_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
